lls_seq: RTL and testbench
==========================

// Module: lls_seq
// PURPOSE
//   Sequential logical left shifter, the counterpart of the combinational 1-bit logical right shift.
//   Accepts one operand and a shift amount over a valid/ready handshake.
//   Shifts left one bit per clock and presents the result over a second valid/ready handshake.
//   Sits in the datapath as the shift-left execution unit; serves SLL-class operations and the multiplier's operand steering.
// PARAMETERS
//   WIDTH    32  operand/result width in bits (>=2)
//   SHAMT_W  5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        operand valid
//   in_ready   out  1        unit can accept an operand
//   in_num     in   WIDTH    operand to shift
//   in_shamt   in   SHAMT_W  left-shift amount, 0..WIDTH-1
//   in_rot     in   1        rotate select (present only with LLS_ROTATE_EN)
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   result     out  WIDTH    shifted value
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, internal regs=0.
//   States:
//     IDLE: in_ready=1.
//     SHIFT: in_ready=0.
//     DONE: in_ready=0, out_valid=1.
//   Accept = in_valid & in_ready, sampled on the rising edge in IDLE.
//     Latch in_num into the work register and in_shamt into the counter.
//     shamt==0 -> DONE on the same edge, result<=in_num.
//     Otherwise -> SHIFT.
//   SHIFT, each edge: work<={work[WIDTH-2:0],1'b0}; cnt<=cnt-1.
//     On the edge where cnt==1, result<=shifted value and state->DONE.
//   Latency: out_valid rises on the edge shamt cycles after the accept edge (shamt=0: the accept edge itself).
//   DONE: result and out_valid held stable until out_valid & out_ready on an edge, then -> IDLE.
//     in_ready rises after that edge.
//   No overlap: at most one operation in flight. in_valid is ignored while in_ready=0.
//   result changes only on the edge entering DONE; it holds its value through IDLE and SHIFT.
//   in_ready and busy are decoded combinationally from state.
//   Shift amounts >= WIDTH cannot occur (SHAMT_W = clog2(WIDTH)).
//   Zero fill at the LSB for logical mode; MSBs shifted out are discarded.
//   Reset mid-operation, in any state: abort immediately to reset values; no partial result is emitted.
// CONFIGURATION
//   LLS_ROTATE_EN defined:
//     in_rot port exists and is latched at accept.
//     in_rot=1: each SHIFT step feeds work[WIDTH-1] into the LSB (rotate left).
//     in_rot=0: logical behaviour as above.
//   LLS_ROTATE_EN undefined: no in_rot port; always logical left shift with zero fill.
// TESTING
//   1. num=32'h0000_0001, shamt=4, out_ready=1 -> result=32'h0000_0010; out_valid exactly 4 cycles after accept, 1 cycle wide.
//   2. num=32'hDEAD_BEEF, shamt=0 -> result=32'hDEAD_BEEF, out_valid after accept edge; in_ready=0 until consumed.
//   3. num=32'h8000_0001, shamt=31 -> result=32'h8000_0000 after 31 cycles; busy high for the whole operation.
//   4. Backpressure: out_ready=0 for 5 cycles after completion.
//      -> out_valid and result stable; new in_valid with num=32'h1234 is not accepted.
//      -> It is accepted on the cycle after out_ready=1.
//   5. Reset asserted after 2 of shamt=10 cycles -> out_valid=0, result=0, in_ready=1 immediately.
//      -> Next op num=32'h3, shamt=2 gives 32'hC.
//   6. LLS_ROTATE_EN: num=32'h8000_0001, shamt=1, rot=1 -> 32'h0000_0003.
//      rot=0 -> 32'h0000_0002.
//      Without the macro the port is absent and the logical result holds.

Source files
------------

// File: rtl/lls_seq.sv
// Sequential left shifter: one bit per clock, valid/ready on both the operand and the result side.
// Optional build macro LLS_ROTATE_EN adds the in_rot port, which selects a rotate-left instead of a zero-fill shift.
module lls_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_num,
  input  logic [SHAMT_W-1:0] in_shamt,
`ifdef LLS_ROTATE_EN
  input  logic               in_rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   shifted;
  logic               accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

`ifdef LLS_ROTATE_EN
  logic rot_q;

  // In rotate mode the bit leaving the MSB re-enters at the LSB.
  assign shifted = {work[WIDTH-2:0], rot_q & work[WIDTH-1]};
`else
  assign shifted = work << 1;
`endif

  // NOTE: every register is cleared by the asynchronous reset, so an aborted
  // operation leaves no stale work, count or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
`ifdef LLS_ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so that every branch reads the
      // pre-edge value of work and cnt.
      case (state)
        IDLE: begin
          if (accept) begin
            work <= in_num;
            cnt  <= in_shamt;
`ifdef LLS_ROTATE_EN
            rot_q <= in_rot;
`endif
            if (in_shamt == '0) begin
              result    <= in_num;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= shifted;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lls_seq.sv
// Bench for lls_seq: a table of shift vectors plus hand-written backpressure and reset-abort sequences.
// Expected results are queued at accept and popped when the result handshake occurs.
module tb_lls_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_num;
  logic [SHAMT_W-1:0] in_shamt;
`ifdef LLS_ROTATE_EN
  logic               in_rot;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               busy;

  lls_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_shamt  (in_shamt),
`ifdef LLS_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [WIDTH-1:0]   num;
    logic [SHAMT_W-1:0] shamt;
    logic               rot;
    logic [WIDTH-1:0]   expv;
  } vec_t;

  vec_t             tbl[$];
  logic [WIDTH-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic pop_check(input string name);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got result %h with no expected value queued", name, result);
    end else begin
      e = exp_q.pop_front();
      check({name, ".result"}, result, e);
    end
  endtask

  task automatic do_op(input string name, input logic [WIDTH-1:0] num,
                       input logic [SHAMT_W-1:0] shamt, input logic rot,
                       input logic [WIDTH-1:0] expv);
    int lat;
    logic busy_ok;
    @(negedge clk);
    check({name, ".in_ready_before"}, WIDTH'(in_ready), WIDTH'(1));
    in_valid = 1'b1;
    in_num   = num;
    in_shamt = shamt;
`ifdef LLS_ROTATE_EN
    in_rot   = rot;
`else
    if (rot) $display("note: %s requests rotate in a logical-only build", name);
`endif
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, ".latency"}, WIDTH'(lat), WIDTH'(shamt));
    check({name, ".busy_during"}, WIDTH'(busy_ok & busy & ~in_ready), WIDTH'(1));
    if (out_valid && out_ready) pop_check(name);
    @(posedge clk);
    #1;
    check({name, ".out_valid_pulse"}, WIDTH'(out_valid), WIDTH'(0));
    check({name, ".in_ready_after"}, WIDTH'(in_ready), WIDTH'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_num    = '0;
    in_shamt  = '0;
`ifdef LLS_ROTATE_EN
    in_rot    = 1'b0;
`endif
    out_ready = 1'b1;

    tbl.push_back('{"one_sh4",     32'h0000_0001, 5'd4,  1'b0, 32'h0000_0010});
    tbl.push_back('{"beef_sh0",    32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{"msb_sh31",    32'h8000_0001, 5'd31, 1'b0, 32'h8000_0000});
    tbl.push_back('{"ones_sh1",    32'hFFFF_FFFF, 5'd1,  1'b0, 32'hFFFF_FFFE});
    tbl.push_back('{"mix_sh8",     32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800});
    tbl.push_back('{"a5_sh16",     32'hA5A5_A5A5, 5'd16, 1'b0, 32'hA5A5_0000});
    tbl.push_back('{"lsb_sh31",    32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000});
    tbl.push_back('{"wrap_log",    32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002});
`ifdef LLS_ROTATE_EN
    tbl.push_back('{"wrap_rot",    32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003});
    tbl.push_back('{"rot_sh31",    32'h8000_0001, 5'd31, 1'b1, 32'hC000_0000});
    tbl.push_back('{"rot_sh4",     32'hF000_000F, 5'd4,  1'b1, 32'h0000_00FF});
`endif

    #12;
    check("reset.in_ready",  WIDTH'(in_ready),  WIDTH'(1));
    check("reset.out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("reset.busy",      WIDTH'(busy),      WIDTH'(0));
    check("reset.result",    result,            '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      do_op(tbl[i].name, tbl[i].num, tbl[i].shamt, tbl[i].rot, tbl[i].expv);

    // Backpressure: result held for 5 cycles, competing operand refused until the slot frees.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_num    = 32'h0000_0005;
    in_shamt  = 5'd3;
    @(posedge clk);
    exp_q.push_back(32'h0000_0028);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp.out_valid_rise", WIDTH'(out_valid), WIDTH'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_num   = 32'h0000_1234;
      in_shamt = 5'd1;
      @(posedge clk);
      #1;
      check("bp.hold_valid", WIDTH'(out_valid), WIDTH'(1));
      check("bp.hold_result", result, 32'h0000_0028);
      check("bp.refuse", WIDTH'(in_ready), WIDTH'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    pop_check("bp.first");
    @(posedge clk);
    #1;
    check("bp.drained_valid", WIDTH'(out_valid), WIDTH'(0));
    check("bp.ready_again", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk);
    exp_q.push_back(32'h0000_2468);
    #1;
    in_valid = 1'b0;
    check("bp.second_accepted", WIDTH'(busy & ~in_ready), WIDTH'(1));
    @(posedge clk);
    #1;
    check("bp.second_valid", WIDTH'(out_valid), WIDTH'(1));
    if (out_valid) pop_check("bp.second");
    @(posedge clk);
    #1;
    check("bp.second_done", WIDTH'(out_valid), WIDTH'(0));

    // Reset two cycles into a 10-step shift: abort at once, nothing emitted.
    @(negedge clk);
    in_valid = 1'b1;
    in_num   = 32'h0000_FFFF;
    in_shamt = 5'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("rst.result",    result,            '0);
    check("rst.in_ready",  WIDTH'(in_ready),  WIDTH'(1));
    check("rst.busy",      WIDTH'(busy),      WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 32'h0000_0003, 5'd2, 1'b0, 32'h0000_000C);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover: got %0d unconsumed results, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
